// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with level, almost flags, FWFT option and sticky errors
module sync_fifo_param #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_AF   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_AE   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wfull_q;
    logic                  rempty_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // rst gating keeps the unreset memory from being written while pointers are held
    assign wr_acc = winc && !wfull_q && !rst;
    assign rd_acc = rinc && !rempty_q;

    always_comb begin
        level_nxt = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + LVL_ONE;
            2'b01:   level_nxt = level_q - LVL_ONE;
            default: level_nxt = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr         <= '0;
            raddr         <= '0;
            level_q       <= '0;
            wfull_q       <= 1'b0;
            rempty_q      <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            rdata_q       <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_acc) begin
                waddr <= waddr + PTR_ONE;
            end
            if (rd_acc) begin
                raddr   <= raddr + PTR_ONE;
                rdata_q <= mem[raddr];
            end
            level_q       <= level_nxt;
            wfull_q       <= (level_nxt == LVL_FULL);
            rempty_q      <= (level_nxt == '0);
            walmost_full  <= (level_nxt >= LVL_AF);
            ralmost_empty <= (level_nxt <= LVL_AE);
            // a new error in the same cycle as clr_err keeps the flag set
            overflow      <= (winc && wfull_q) || (overflow && !clr_err);
            underflow     <= (rinc && rempty_q) || (underflow && !clr_err);
        end
    end

    // in FWFT mode rdata_q holds the last popped word, shown while empty
    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = rempty_q ? rdata_q : mem[raddr];
        end else begin : g_std
            assign rdata = rdata_q;
        end
    endgenerate

    assign wfull  = wfull_q;
    assign rempty = rempty_q;
    assign level  = level_q;

endmodule
